// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences machine-mode trap entry and mret return.
// It watches the commit stage for ecall, ebreak and mret, and also
// watches the masked machine-timer interrupt.
// On an event it stalls the pipeline, waits for AXI traffic to drain,
// strobes the CSR file, then flushes and redirects the PC.
// Build option: define TRAP_VECTORED_EN to enable vectored interrupt
// targets (mtvec[1:0]==2'b01). When it is undefined, every trap goes to
// the mtvec base.
module trap_ctrl #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_valid,
  input  logic [ADDR_W-1:0] commit_pc,
  input  logic              commit_ecall,
  input  logic              commit_ebreak,
  input  logic              commit_mret,
  input  logic [ADDR_W-1:0] nxt_pc,
  input  logic              clint_mtip,
  input  logic              mstatus_mie,
  input  logic              mie_mtie,
  input  logic [DATA_W-1:0] mtvec,
  input  logic [ADDR_W-1:0] mepc,
  input  logic              mem_busy,
  output logic              stall_req,
  output logic              trap_save,
  output logic [ADDR_W-1:0] save_epc,
  output logic [DATA_W-1:0] save_cause,
  output logic              ret_en,
  output logic              flush,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       trap_cnt
);

  typedef enum logic [1:0] {IDLE, DRAIN, SAVE, JUMP} state_t;

  localparam logic [DATA_W-1:0] CAUSE_ECALL  = DATA_W'(11);
  localparam logic [DATA_W-1:0] CAUSE_EBREAK = DATA_W'(3);
  localparam logic [DATA_W-1:0] CAUSE_MTI    = {1'b1, {(DATA_W-4){1'b0}}, 3'b111};

  state_t            state, state_nxt;
  logic              irq_pend;
  logic              ev_any;
  logic              ev_ret;
  logic [DATA_W-1:0] ev_cause;
  logic [ADDR_W-1:0] ev_epc;
  logic              kind_ret;
  logic [DATA_W-1:0] cause_lat;
  logic [ADDR_W-1:0] epc_lat;
  logic [ADDR_W-1:0] trap_base;
  logic [ADDR_W-1:0] trap_target;

  assign irq_pend  = clint_mtip & mie_mtie & mstatus_mie;
  assign trap_base = {mtvec[ADDR_W-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  // Vectored mode sends interrupts to base + 4*cause; exceptions still use base.
  always_comb begin
    trap_target = trap_base;
    if (mtvec[1:0] == 2'b01 && cause_lat[DATA_W-1])
      trap_target = trap_base + ADDR_W'({cause_lat[5:0], 2'b00});
  end
`else
  logic unused_mode;
  assign unused_mode = ^mtvec[1:0];
  assign trap_target = trap_base;
`endif

  // Event priority: ecall > ebreak > mret > timer interrupt.
  always_comb begin
    ev_any   = 1'b0;
    ev_ret   = 1'b0;
    ev_cause = '0;
    ev_epc   = '0;
    if (commit_valid && commit_ecall) begin
      ev_any   = 1'b1;
      ev_cause = CAUSE_ECALL;
      ev_epc   = commit_pc;
    end else if (commit_valid && commit_ebreak) begin
      ev_any   = 1'b1;
      ev_cause = CAUSE_EBREAK;
      ev_epc   = commit_pc;
    end else if (commit_valid && commit_mret) begin
      ev_any   = 1'b1;
      ev_ret   = 1'b1;
    end else if (irq_pend) begin
      ev_any   = 1'b1;
      ev_cause = CAUSE_MTI;
      ev_epc   = nxt_pc;
    end
  end

  // State register; reset aborts any sequence in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Event details are frozen at detection, so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && ev_any) begin
      kind_ret  <= ev_ret;
      cause_lat <= ev_cause;
      epc_lat   <= ev_epc;
    end
  end

  // Count completed trap entries; returns do not count.
  always_ff @(posedge clk) begin
    if (rst)                         trap_cnt <= '0;
    else if (state == JUMP && !kind_ret) trap_cnt <= trap_cnt + 32'd1;
  end

  // Next-state logic and state-decoded outputs (all derive from the state register).
  always_comb begin
    state_nxt      = state;
    stall_req      = 1'b0;
    trap_save      = 1'b0;
    save_epc       = '0;
    save_cause     = '0;
    ret_en         = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      IDLE: begin
        if (ev_any) state_nxt = DRAIN;
      end
      DRAIN: begin
        stall_req = 1'b1;
        if (!mem_busy) state_nxt = kind_ret ? JUMP : SAVE;
      end
      SAVE: begin
        stall_req  = 1'b1;
        trap_save  = 1'b1;
        save_epc   = epc_lat;
        save_cause = cause_lat;
        state_nxt  = JUMP;
      end
      JUMP: begin
        stall_req      = 1'b1;
        flush          = 1'b1;
        redirect_valid = 1'b1;
        ret_en         = kind_ret;
        redirect_pc    = kind_ret ? mepc : trap_target;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed testbench for trap_ctrl.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic        commit_ecall;
  logic        commit_ebreak;
  logic        commit_mret;
  logic [63:0] nxt_pc;
  logic        clint_mtip;
  logic        mstatus_mie;
  logic        mie_mtie;
  logic [63:0] mtvec;
  logic [63:0] mepc;
  logic        mem_busy;
  logic        stall_req;
  logic        trap_save;
  logic [63:0] save_epc;
  logic [63:0] save_cause;
  logic        ret_en;
  logic        flush;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [31:0] trap_cnt;

  int checks = 0;
  int errors = 0;

  trap_ctrl #(.DATA_W(64), .ADDR_W(64)) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_ecall(commit_ecall), .commit_ebreak(commit_ebreak),
    .commit_mret(commit_mret), .nxt_pc(nxt_pc),
    .clint_mtip(clint_mtip), .mstatus_mie(mstatus_mie), .mie_mtie(mie_mtie),
    .mtvec(mtvec), .mepc(mepc), .mem_busy(mem_busy),
    .stall_req(stall_req), .trap_save(trap_save),
    .save_epc(save_epc), .save_cause(save_cause),
    .ret_en(ret_en), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .trap_cnt(trap_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Packed view of every 1-bit strobe: {stall, save, ret, flush, redir}
  function automatic logic [63:0] ctl();
    return {59'd0, stall_req, trap_save, ret_en, flush, redirect_valid};
  endfunction

  task automatic clr_commit();
    commit_valid  = 1'b0;
    commit_ecall  = 1'b0;
    commit_ebreak = 1'b0;
    commit_mret   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr_commit();
    commit_pc   = '0;
    nxt_pc      = '0;
    clint_mtip  = 1'b0;
    mstatus_mie = 1'b0;
    mie_mtie    = 1'b0;
    mtvec       = 64'h8000_0004;
    mepc        = '0;
    mem_busy    = 1'b0;
    step();
    step();
    chk("rst_ctl", ctl(), 64'd0);
    chk("rst_epc", save_epc, 64'd0);
    chk("rst_cause", save_cause, 64'd0);
    chk("rst_rpc", redirect_pc, 64'd0);
    chk("rst_cnt", {32'd0, trap_cnt}, 64'd0);
    rst = 1'b0;
    step();

    // ecall, no memory traffic
    commit_valid = 1'b1; commit_ecall = 1'b1; commit_pc = 64'h8000_0100;
    step();
    clr_commit(); commit_pc = 64'h1234;
    chk("ec_drain_ctl", ctl(), 64'b10000);
    step();
    chk("ec_save_ctl", ctl(), 64'b11000);
    chk("ec_save_epc", save_epc, 64'h8000_0100);
    chk("ec_save_cause", save_cause, 64'd11);
    step();
    chk("ec_jump_ctl", ctl(), 64'b10011);
    chk("ec_jump_rpc", redirect_pc, 64'h8000_0004);
    step();
    chk("ec_idle_ctl", ctl(), 64'd0);
    chk("ec_cnt", {32'd0, trap_cnt}, 64'd1);

    // timer interrupt with memory busy during drain
    mstatus_mie = 1'b1; mie_mtie = 1'b1; clint_mtip = 1'b1;
    nxt_pc = 64'h8000_0200; mem_busy = 1'b1;
    step();
    clint_mtip = 1'b0; nxt_pc = 64'hDEAD_0000;
    for (int i = 0; i < 4; i++) begin
      chk("irq_drain_ctl", ctl(), 64'b10000);
      step();
    end
    chk("irq_drain_last", ctl(), 64'b10000);
    mem_busy = 1'b0;
    step();
    chk("irq_save_ctl", ctl(), 64'b11000);
    chk("irq_save_cause", save_cause, 64'h8000_0000_0000_0007);
    chk("irq_save_epc", save_epc, 64'h8000_0200);
    step();
    chk("irq_jump_ctl", ctl(), 64'b10011);
    chk("irq_jump_rpc", redirect_pc, 64'h8000_0004);
    step();
    chk("irq_cnt", {32'd0, trap_cnt}, 64'd2);

    // mret
    mepc = 64'h8000_0300;
    commit_valid = 1'b1; commit_mret = 1'b1;
    step();
    clr_commit();
    chk("ret_drain_ctl", ctl(), 64'b10000);
    step();
    chk("ret_jump_ctl", ctl(), 64'b10111);
    chk("ret_jump_rpc", redirect_pc, 64'h8000_0300);
    step();
    chk("ret_idle_ctl", ctl(), 64'd0);
    chk("ret_cnt", {32'd0, trap_cnt}, 64'd2);

    // ebreak races a pending timer interrupt; mtvec requests vectored mode
    mtvec = 64'h8000_1001;
    commit_valid = 1'b1; commit_ebreak = 1'b1; commit_pc = 64'h8000_0400;
    clint_mtip = 1'b1; nxt_pc = 64'h8000_0500;
    step();
    clr_commit();
    step();
    chk("eb_save_cause", save_cause, 64'd3);
    chk("eb_save_epc", save_epc, 64'h8000_0400);
    step();
    chk("eb_jump_rpc", redirect_pc, 64'h8000_1000);
    step();
    chk("eb_idle_ctl", ctl(), 64'd0);
    chk("eb_cnt", {32'd0, trap_cnt}, 64'd3);
    step();
    chk("eb_irq_drain", ctl(), 64'b10000);
    clint_mtip = 1'b0;
    step();
    chk("eb_irq_cause", save_cause, 64'h8000_0000_0000_0007);
    chk("eb_irq_epc", save_epc, 64'h8000_0500);
    step();
`ifdef TRAP_VECTORED_EN
    chk("vec_irq_rpc", redirect_pc, 64'h8000_101C);
`else
    chk("base_irq_rpc", redirect_pc, 64'h8000_1000);
`endif
    step();
    chk("eb_irq_cnt", {32'd0, trap_cnt}, 64'd4);

    // reset during drain aborts the sequence
    mtvec = 64'h8000_0004;
    mem_busy = 1'b1;
    commit_valid = 1'b1; commit_ecall = 1'b1; commit_pc = 64'h8000_0600;
    step();
    clr_commit();
    chk("rd_drain_ctl", ctl(), 64'b10000);
    rst = 1'b1;
    step();
    chk("rd_rst_ctl", ctl(), 64'd0);
    chk("rd_rst_cnt", {32'd0, trap_cnt}, 64'd0);
    rst = 1'b0; mem_busy = 1'b0;
    step();
    chk("rd_quiet1", ctl(), 64'd0);
    step();
    chk("rd_quiet2", ctl(), 64'd0);

    // fresh ecall, with ebreak asserted too (ecall must win)
    commit_valid = 1'b1; commit_ecall = 1'b1; commit_ebreak = 1'b1;
    commit_pc = 64'h8000_0700;
    step();
    clr_commit();
    step();
    chk("fr_save_ctl", ctl(), 64'b11000);
    chk("fr_save_cause", save_cause, 64'd11);
    chk("fr_save_epc", save_epc, 64'h8000_0700);
    step();
    chk("fr_jump_rpc", redirect_pc, 64'h8000_0004);
    step();
    chk("fr_cnt", {32'd0, trap_cnt}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
